// File: rtl/overlay_bit_packer.sv
// Overlay capture packer: thresholds RGB luma into a 1bpp mask and
// writes packed mask words to the overlay bitmap RAM, one frame per start.
module overlay_bit_packer #(
    parameter int WORD_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        threshold,
    input  logic              invert,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [23:0]       pix_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int IDX_W = $clog2(WORD_W);

    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [IDX_W-1:0]  IDX_ONE  = 1;
    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        FLUSH,
        DONE
    } state_t;

    state_t             state;
    logic [7:0]         thrQ;
    logic               invQ;
    logic [CNT_W-1:0]   pixCnt;
    logic [IDX_W-1:0]   bitIdx;
    logic [WORD_W-1:0]  shiftReg;
    logic [ADDR_W-1:0]  wordAddr;

    logic [9:0]         lumaSum;
    logic [7:0]         luma;
    logic               pixBit;
    logic               accept;
    logic               restart;
    logic [IDX_W-1:0]   curIdx;
    logic [CNT_W-1:0]   curCnt;
    logic [WORD_W-1:0]  curWord;
    logic [ADDR_W-1:0]  curAddr;
    logic               curFull;
    logic               curLast;

    // A SOF pixel either opens the frame or restarts an interrupted one,
    // so both paths pack it from a cleared word/count/address.
    always_comb begin
        lumaSum = {2'b00, pix_data[23:16]} + {1'b0, pix_data[15:8], 1'b0}
                + {2'b00, pix_data[7:0]};
        luma    = lumaSum[9:2];
        pixBit  = (luma >= thrQ) ^ invQ;
        accept  = pix_valid && ((state == WAIT_SOF && pix_sof) || state == CAPTURE);
        restart = (state == WAIT_SOF) || (pix_sof && pixCnt != LAST);
        curIdx  = restart ? '0 : bitIdx;
        curCnt  = restart ? '0 : pixCnt;
        curAddr = restart ? '0 : wordAddr;
        curWord = (restart ? '0 : shiftReg) | (WORD_W'(pixBit) << curIdx);
        curFull = (curIdx == IDX_TOP);
        curLast = (curCnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            thrQ      <= '0;
            invQ      <= 1'b0;
            pixCnt    <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            wordAddr  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        thrQ     <= threshold;
                        invQ     <= invert;
                        busy     <= 1'b1;
                        pixCnt   <= '0;
                        bitIdx   <= '0;
                        shiftReg <= '0;
                        wordAddr <= '0;
                        state    <= WAIT_SOF;
                    end
                end
                WAIT_SOF, CAPTURE: begin
                    if (accept) begin
                        frame_err <= (state == CAPTURE) && restart;
                        pixCnt    <= curCnt + CNT_ONE;
                        if (curFull) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= curAddr;
                            mem_wdata <= curWord;
                            wordAddr  <= curAddr + ADDR_ONE;
                            shiftReg  <= '0;
                            bitIdx    <= '0;
                        end else begin
                            wordAddr  <= curAddr;
                            shiftReg  <= curWord;
                            bitIdx    <= curIdx + IDX_ONE;
                        end
                        if (curLast)
                            state <= curFull ? DONE : FLUSH;
                        else
                            state <= CAPTURE;
                    end
                end
                FLUSH: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wordAddr;
                    mem_wdata <= shiftReg;
                    wordAddr  <= wordAddr + ADDR_ONE;
                    shiftReg  <= '0;
                    bitIdx    <= '0;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/overlay_bit_packer.md
Name: overlay_bit_packer

Overview:
- Capture-side counterpart of the overlay bit expander: converts a 24-bit RGB pixel stream into a 1-bit-per-pixel overlay mask.
- Packs mask bits into memory words and writes them to the overlay bitmap RAM.
- The display path later reads this RAM and expands each bit back to a pixel.
- Sits between the video input pixel stream and the overlay RAM write port; captures exactly one frame per start request.

Parameters:
- WORD_W, 8, mask bits per RAM word (power of 2, 2..32).
- ADDR_W, 16, RAM word address width.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.

Ports:
- clk  input  1  pixel clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  arm a single-frame capture (pulse).
- threshold  input  8  luma threshold, sampled at start.
- invert  input  1  invert mask polarity, sampled at start.
- pix_valid  input  1  pixel qualifier; one active pixel per valid cycle; no backpressure.
- pix_sof  input  1  first pixel of frame; only meaningful with pix_valid.
- pix_data  input  24  {R[23:16], G[15:8], B[7:0]}.
- mem_we  output  1  RAM write strobe, one cycle per word.
- mem_addr  output  ADDR_W  RAM word address.
- mem_wdata  output  WORD_W  packed mask word.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse at capture completion.
- frame_err  output  1  one-cycle pulse on an early SOF.

Behaviour:
- Reset:
  - While reset_n=0 at a clk edge: state IDLE; all outputs 0; pixel count, bit index, address and shift register cleared.
  - No write is issued from reset until the next start.
- Mask bit:
  - luma = (R + 2*G + B) >> 2, using a 10-bit sum then an 8-bit result.
  - bit = (luma >= threshold_q) XOR invert_q.
- Packing:
  - The first pixel of the frame goes to bit 0; the bit index increments per accepted pixel.
  - Pixel k maps to word k/WORD_W, bit k%WORD_W.
- States:
  - IDLE: pixels ignored. start=1 -> latch threshold/invert, busy=1, go to WAIT_SOF.
  - WAIT_SOF: pixels without pix_sof are discarded. pix_valid & pix_sof -> that pixel is pixel 0, go to CAPTURE.
  - CAPTURE: every pix_valid pixel is packed.
    - When bit WORD_W-1 is filled, the word is written.
    - After pixel H_ACTIVE*V_ACTIVE-1: if a partial word is pending, go to FLUSH; otherwise go to DONE.
  - FLUSH: write the partial word with its unfilled high bits = 0, then go to DONE. One cycle; pixels in this cycle are ignored.
  - DONE: done=1, busy=0, go to IDLE. Pixels are ignored.
- Write timing:
  - The word completed by the pixel accepted at edge N appears with mem_we=1, mem_addr, mem_wdata at edge N+1, held for exactly one cycle.
  - mem_addr starts at 0 each frame and increments after each write.
  - mem_addr for the last write = ceil(H_ACTIVE*V_ACTIVE / WORD_W) - 1.
  - mem_we=0 in all other cycles.
- Boundaries:
  - start while busy: ignored; the latched threshold is unchanged.
  - pix_sof with pix_valid in CAPTURE before the pixel count completes:
    - frame_err pulses the next cycle.
    - The partial word is discarded, not written.
    - The address, bit index and count reset, and that SOF pixel becomes pixel 0 of a new capture.
    - busy stays 1.
  - pix_sof on the pixel that completes the count: impossible for a consistent source; it is treated as an ordinary last pixel.
  - Gaps in pix_valid: no effect other than stall. There is no timeout.
  - Address wrap: mem_addr wraps modulo 2^ADDR_W. Sizing is the integrator's responsibility.
  - Reset mid-capture: immediate abort; no flush write; busy=0 and done=0.
  - pix_valid=0 cycles never change the shift register or count.
- Arithmetic:
  - The pixel counter is ceil(log2(H_ACTIVE*V_ACTIVE+1)) bits wide.
  - The luma sum is 10 bits, so it cannot overflow.

Test Plan:
- Params WORD_W=8, H=8, V=2; start, threshold=0x80, invert=0; 16 pixels alternating 0xFFFFFF/0x000000 from SOF -> writes (addr0, 0x55) then (addr1, 0x55); done pulses 1 cycle after the second write; busy low with done.
- Same setup with H=5, V=2 (10 pixels) all white -> (addr0, 0xFF), then FLUSH writes (addr1, 0x03); done follows.
- Threshold edge: pixel 0x808080 with threshold=0x80 -> bit 1; 0x7F7F7F -> bit 0; with invert=1 the bits flip. Check pixel 0x00FF00: luma = 0x7F -> bit 0.
- Before SOF, 3 valid non-SOF white pixels, then SOF with black pixels -> the first word written is 0x00, proving the pre-SOF pixels were discarded.
- SOF on pixel 5 of a capture -> frame_err pulses, no write for the aborted word, the next write is at addr 0; a second start during capture does not alter threshold_q.
- reset_n=0 for 1 cycle mid-CAPTURE -> all outputs 0 next cycle, no further mem_we, and the state stays IDLE until start.
